// File: rtl/alu_mdu_if.sv
// Handshake/operand bundle between the EX-stage pipeline control and alu_mdu.
interface alu_mdu_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] opr1;
   logic [XLEN-1:0] opr2;
   logic [3:0]      alu_ctrl;
   logic            m_ext;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_out;
   logic            zero;
   logic            busy;

   modport master (
      output in_valid, opr1, opr2, alu_ctrl, m_ext, out_ready,
      input  in_ready, out_valid, alu_out, zero, busy
   );

   modport slave (
      input  in_valid, opr1, opr2, alu_ctrl, m_ext, out_ready,
      output in_ready, out_valid, alu_out, zero, busy
   );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU with a registered result plus iterative RV32M multiply/divide.
// Define ALU_MDU_MULDIV_EN to compile in the M-extension datapath, BUSY state and counter.
module alu_mdu #(
   parameter int unsigned XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   alu_mdu_if.slave  bus
);

   localparam int unsigned SHW = $clog2(XLEN);

`ifdef ALU_MDU_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

   state_e          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            zero_q, zero_d;
   logic [XLEN-1:0] alu_out_q, alu_out_d;

   logic [XLEN-1:0] a, b, base_res;
   logic [SHW-1:0]  shamt;
   logic            slt, sltu;

   assign a     = bus.opr1;
   assign b     = bus.opr2;
   assign shamt = b[SHW-1:0];
   assign slt   = $signed(a) < $signed(b);
   assign sltu  = a < b;

   // Base integer ALU, decoded on {funct7[5], funct3}
   always_comb begin
      base_res = '0;
      case (bus.alu_ctrl)
         4'b0000: base_res = a + b;
         4'b1000: base_res = a - b;
         4'b0001: base_res = a << shamt;
         4'b0010: base_res = XLEN'(slt);
         4'b0011: base_res = XLEN'(sltu);
         4'b0100: base_res = a ^ b;
         4'b0101: base_res = a >> shamt;
         4'b1101: base_res = XLEN'($signed(a) >>> shamt);
         4'b0110: base_res = a | b;
         4'b0111: base_res = a & b;
         default: base_res = '0;
      endcase
   end

`ifdef ALU_MDU_MULDIV_EN
   localparam int unsigned CW = SHW + 1;

   logic [2*XLEN-1:0] prod_q, prod_d, step, full;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;

   logic [2:0]        f3;
   logic              a_neg, b_neg, div0, ovf;
   logic [XLEN-1:0]   mag_a, mag_b, spec_res, quo, rem, m_res;
   logic [XLEN:0]     hi_sum, cand, diff;

   // Operand magnitudes and single-cycle divide special cases, evaluated at accept
   always_comb begin
      f3       = bus.alu_ctrl[2:0];
      a_neg    = a[XLEN-1] & ((f3 == 3'd1) | (f3 == 3'd2) | (f3 == 3'd4) | (f3 == 3'd6));
      b_neg    = b[XLEN-1] & ((f3 == 3'd1) | (f3 == 3'd4) | (f3 == 3'd6));
      mag_a    = a_neg ? -a : a;
      mag_b    = b_neg ? -b : b;
      div0     = f3[2] & (b == '0);
      ovf      = f3[2] & ~f3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
      spec_res = div0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
   end

   // One shift-add or restoring subtract-shift step, plus sign fix-up of the final step
   always_comb begin
      hi_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
      cand   = prod_q[2*XLEN-1:XLEN-1];
      diff   = cand - {1'b0, opb_q};
      if (op_q[2]) begin
         step = {(diff[XLEN] ? cand[XLEN-1:0] : diff[XLEN-1:0]), prod_q[XLEN-2:0], ~diff[XLEN]};
      end else begin
         step = {hi_sum, prod_q[XLEN-1:1]};
      end
      full = neg_q ? -step : step;
      quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      rem  = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:                m_res = full[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    m_res = full[2*XLEN-1:XLEN];
         3'd4, 3'd5:          m_res = quo;
         default:             m_res = rem;
      endcase
   end
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      alu_out_d = alu_out_q;
`ifdef ALU_MDU_MULDIV_EN
      prod_d    = prod_q;
      opb_d     = opb_q;
      op_d      = op_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (!bus.m_ext) begin
                  state_d   = DONE;
                  alu_out_d = base_res;
`ifdef ALU_MDU_MULDIV_EN
               end else if (div0 || ovf) begin
                  state_d   = DONE;
                  alu_out_d = spec_res;
               end else begin
                  state_d = BUSY;
                  op_d    = f3;
                  neg_d   = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
                  prod_d  = f3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                  opb_d   = f3[2] ? mag_b : mag_a;
                  cnt_d   = '0;
               end
`else
               end else begin
                  state_d   = DONE;
                  alu_out_d = '0;
               end
`endif
            end
         end
`ifdef ALU_MDU_MULDIV_EN
         BUSY: begin
            prod_d = step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
               state_d   = DONE;
               alu_out_d = m_res;
            end
         end
`endif
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      zero_d      = (alu_out_d == '0);
`ifdef ALU_MDU_MULDIV_EN
      busy_d      = (state_d == BUSY);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b1;
         alu_out_q   <= '0;
`ifdef ALU_MDU_MULDIV_EN
         prod_q      <= '0;
         opb_q       <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         alu_out_q   <= alu_out_d;
`ifdef ALU_MDU_MULDIV_EN
         prod_q      <= prod_d;
         opb_q       <= opb_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.alu_out   = alu_out_q;
   assign bus.zero      = zero_q;
`ifdef ALU_MDU_MULDIV_EN
   assign bus.busy      = busy_q;
`else
   assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed corner cases plus randomized ops against a reference model.
module tb_alu_mdu;
   localparam int unsigned XLEN = 32;
`ifdef ALU_MDU_MULDIV_EN
   localparam int MLAT     = int'(XLEN) + 1;
   localparam int BUSY_EXP = int'(XLEN);
`else
   localparam int MLAT     = 1;
   localparam int BUSY_EXP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_mdu_if #(.XLEN(XLEN)) bus ();
   alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   bp_mode = 0;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: architectural result from plain wide arithmetic
   function automatic logic [31:0] model(input logic [3:0] c, input logic m,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
`ifdef ALU_MDU_MULDIV_EN
      logic [63:0] p;
      longint      sx, sy, uy;
      sx = longint'($signed(a));
      sy = longint'($signed(b));
      uy = longint'({32'b0, b});
`endif
      r = '0;
      if (m) begin
`ifdef ALU_MDU_MULDIV_EN
         case (c[2:0])
            3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
            3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
            3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
               if (b == 0) r = 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
               else r = 32'(sx / sy);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
               if (b == 0) r = a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
               else r = 32'(sx % sy);
            end
            default: r = (b == 0) ? a : a % b;
         endcase
`endif
      end else begin
         case (c)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: r = 32'($signed(a) >>> b[4:0]);
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   function automatic int lat_of(input logic [3:0] c, input logic m,
                                 input logic [31:0] a, input logic [31:0] b);
      logic special;
      int   l;
      special = c[2] && (b == 0 || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      l = 1;
      if (m && !special) l = MLAT;
      return l;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'h7FFF_FFFF;
         5: v = 32'($urandom_range(0, 15));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one request; expected response goes to the scoreboard at the accept edge
   task automatic issue(input logic [3:0] c, input logic m, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         chk_int("accept_timeout", n, 0);
      end else begin
         bus.in_valid = 1'b1;
         bus.alu_ctrl = c;
         bus.m_ext    = m;
         bus.opr1     = a;
         bus.opr2     = b;
         sb.push_back('{res: model(c, m, a, b), lat: lat_of(c, m, a, b), acc: cyc + 1});
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.alu_ctrl = 4'($urandom);
         bus.m_ext    = 1'($urandom);
         bus.opr1     = $urandom;
         bus.opr2     = $urandom;
      end
   endtask

   // Consumer readiness: always, random, or stalled
   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: latency on out_valid rise, value and zero on each handshake
   always @(negedge clk) begin
      if (rst) begin
         ov_prev = 1'b0;
      end else begin
         if (bus.out_valid && !ov_prev) begin
            if (sb.size() == 0) chk_int("unexpected_out_valid", 1, 0);
            else chk_int("latency", cyc - sb[0].acc + 1, sb[0].lat);
         end
         if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("alu_out", bus.alu_out, e.res);
            chk("zero", {31'b0, bus.zero}, {31'b0, (e.res == 32'd0)});
         end
         ov_prev = bus.out_valid;
      end
   end

   logic [3:0] ops [10];
   logic [3:0] ctrl;
   logic       m;
   int         n, k;

   initial begin
      ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
              4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.alu_ctrl  = 4'b0;
      bus.m_ext     = 1'b0;
      bus.opr1      = '0;
      bus.opr2      = '0;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_alu_out", bus.alu_out, 32'd0);
      chk("rst_zero", {31'b0, bus.zero}, 32'd1);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      #2 rst = 1'b0;

      // Directed cases
      issue(4'b0000, 1'b0, 32'd5, 32'd7);
      issue(4'b1000, 1'b0, 32'd7, 32'd7);
      issue(4'b1101, 1'b0, 32'h8000_0000, 32'd36);
      issue(4'b0101, 1'b0, 32'h8000_0000, 32'd36);
      issue(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n = 0;
      k = 0;
      while (!bus.out_valid && k < 100) begin
         if (bus.busy) n++;
         k++;
         @(negedge clk);
      end
      chk_int("mulhu_busy_cycles", n, BUSY_EXP);
      issue(4'b0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'b0001, 1'b1, 32'hFFFF_FFFD, 32'd5);
      issue(4'b0100, 1'b1, 32'd7, 32'd0);
      issue(4'b0110, 1'b1, 32'd7, 32'd0);
      issue(4'b0100, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'b0110, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'b0100, 1'b1, 32'hFFFF_FFF9, 32'd2);
      issue(4'b0110, 1'b1, 32'hFFFF_FFF9, 32'd2);

      // Backpressure: result and in_ready held while the consumer stalls
      bp_mode = 2;
      issue(4'b0101, 1'b1, 32'd100, 32'd7);
      k = 0;
      while (!bus.out_valid && k < 100) begin
         k++;
         @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_alu_out_hold", bus.alu_out, model(4'b0101, 1'b1, 32'd100, 32'd7));
         chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
         @(negedge clk);
      end
      bp_mode = 0;
      repeat (2) @(negedge clk);
      chk("bp_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
      chk("bp_out_valid_after", {31'b0, bus.out_valid}, 32'd0);

      // Reset in the middle of a multiply
      issue(4'b0000, 1'b1, 32'h1234_5678, 32'h9ABC_DEF1);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
      chk("midrst_alu_out", bus.alu_out, 32'd0);
      chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      sb.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      issue(4'b0000, 1'b0, 32'd40, 32'd2);

      // Randomized traffic with random consumer stalls
      for (int i = 0; i < 60; i++) begin
         bp_mode = $urandom_range(0, 1);
         m = ($urandom_range(0, 2) == 0);
         if (m) ctrl = {1'b0, 3'($urandom_range(0, 7))};
         else if ($urandom_range(0, 7) == 0) ctrl = 4'($urandom);
         else ctrl = ops[$urandom_range(0, 9)];
         issue(ctrl, m, pick(), pick());
      end

      bp_mode = 0;
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         k++;
         @(negedge clk);
      end
      chk_int("drain_pending", sb.size(), 0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Multi-cycle, parametrised execute unit that replaces the single-cycle combinational ALU in the EX stage. It performs every RV32I integer ALU operation with a one-cycle registered result. It also performs the RV32M multiply/divide operations iteratively. Operands enter and results leave through valid/ready handshakes, so the pipeline control stalls EX while a long operation is in flight.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- opr1  in  XLEN  operand 1 (rs1)
- opr2  in  XLEN  operand 2 (rs2 or immediate)
- alu_ctrl  in  4  {funct7[5], funct3}; encoding identical to the existing ALU control
- m_ext  in  1  1 = RV32M op; funct3 = alu_ctrl[2:0] selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- alu_out  out  XLEN  result
- zero  out  1  alu_out == 0, registered with alu_out
- busy  out  1  iterative operation in progress

## Operation
- FSM states: IDLE, BUSY, DONE.
  - Reset state is IDLE.
  - Reset values: out_valid=0, alu_out=0, zero=1, busy=0, in_ready=1.
- in_ready = (state==IDLE). A request is accepted on a rising edge where in_valid && in_ready. Operands are captured at that edge.
- Base ops (m_ext=0): the result is computed combinationally, registered, and the FSM goes IDLE→DONE.
  - Shifts use opr2[SHW-1:0] only.
  - SRA is arithmetic.
  - SLT is signed; SLTU is unsigned.
  - Undefined alu_ctrl → 0.
- M ops, normal case: IDLE→BUSY.
  - Operands are converted to magnitudes per signedness: MULH both signed, MULHSU opr1 signed, DIV/REM signed.
  - The operation runs XLEN iterations of shift-add (multiply) or restoring subtract-shift (divide), one per cycle, on a SHW+1-bit counter.
  - The 2·XLEN product, quotient, or remainder is negated when the sign rule requires it.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - REM takes the sign of the dividend.
  - On the last iteration the FSM goes BUSY→DONE.
- Divide special cases bypass BUSY and go IDLE→DONE in one cycle:
  - divisor 0: DIV/DIVU = all ones; REM/REMU = opr1.
  - signed overflow (opr1 = 1<<(XLEN-1), opr2 = all ones): DIV = opr1, REM = 0.
- DONE: out_valid=1, and alu_out/zero are held stable until out_valid && out_ready, then DONE→IDLE.
  - No new request is accepted in the same cycle as the result handshake.
- busy=1 only in BUSY.
- in_valid and m_ext are ignored outside IDLE. opr changes during BUSY have no effect.

## Timing
- Base op or divide special case: out_valid rises 1 cycle after accept.
- Iterative M op: out_valid rises XLEN+1 cycles after accept (33 for XLEN=32).
- Throughput without backpressure:
  - Base op: one result every 2 cycles.
  - Iterative M op: one result every XLEN+2 cycles.
- Backpressure (out_ready=0) extends DONE indefinitely; the result does not change.
- rst asserted mid-operation (BUSY or DONE) immediately forces IDLE and the reset output values. The partial result is discarded and no out_valid is produced for it.

## Configuration
- ALU_MDU_MULDIV_EN defined: the M-extension datapath, BUSY state and iteration counter are compiled in, behaving as described above.
- ALU_MDU_MULDIV_EN undefined: the datapath, BUSY state and counter are absent.
  - Every m_ext=1 request completes like a base op with alu_out=0 and 1-cycle latency.
  - busy is tied to 0.

## Test plan
- Reset then ADD 5+7 (ctrl 0000) with out_ready=1 → out_valid 1 cycle after accept, alu_out=12, zero=0. SUB 7-7 → 0, zero=1.
- SRA 0x80000000 by opr2=36 (ctrl 1101) → 0xF8000000 (shift masked to 4). SRL same operands → 0x08000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE at cycle 33 after accept, busy high for 32 cycles. MUL same operands → 0x00000001. MULH -3×5 → 0xFFFFFFFF.
- DIV 7/0 → 0xFFFFFFFF and REM 7/0 → 7, both in 1 cycle. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. DIV -7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- Backpressure on DIVU 100/7: hold out_ready=0 for 10 cycles after out_valid → alu_out stays 14 and in_ready stays 0. Release → one handshake, then in_ready=1.
- Assert rst at iteration 10 of a MUL → out_valid=0, busy=0, alu_out=0 immediately. A fresh ADD after release completes normally.
